// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: streams operands LSB-first through an external 1-bit full adder.
// Define SERIAL_ADDER_SUB_EN to add the op_sub port (A - B via ~B and forced carry-in of 1).
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             op_sub,
`endif
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              shift_q, shift_d;
  logic              sub_sel;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_sel = op_sub;
`else
  assign sub_sel = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_d       = res_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    shift_d     = shift_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d    = StShift;
          a_sh_d     = op_a;
          b_sh_d     = sub_sel ? ~op_b : op_b;
          carry_d    = sub_sel ? 1'b1 : op_cin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          shift_d    = 1'b1;
        end
      end

      StShift: begin
        // Sum bits enter at the MSB so bit 0 ends up at sum[0] after WIDTH shifts.
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = fa_s;
        a_sh_d           = a_sh_q >> 1;
        b_sh_d           = b_sh_q >> 1;
        carry_d          = fa_cout;
        cnt_d            = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d     = StDone;
          cnt_d       = '0;
          sum_d       = res_d;
          cout_d      = fa_cout;
          out_valid_d = 1'b1;
          shift_d     = 1'b0;
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = StIdle;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        shift_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      shift_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_q       <= res_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      shift_q     <= shift_d;
    end
  end

  // Full-adder drive is gated so the adder sees zeros whenever no bit is in flight.
  assign fa_a      = shift_q & a_sh_q[0];
  assign fa_b      = shift_q & b_sh_q[0];
  assign fa_cin    = shift_q & carry_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
